// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way set-associative L1 cache datapath.
// Define CACHE_PERF_CNT_EN to add the hit/miss/writeback counters.
module cache_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic             hit,
    input  logic             valid,
    input  logic             dirty,
    input  logic             pmem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             load_tag,
    output logic             load_mem,
    output logic             set_valid,
    output logic             set_clean,
    output logic             set_dirty,
    output logic             load_lru,
    output logic             way_sel,
    output logic             addr_sel
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   req;

    assign req = mem_read | mem_write;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req) state_d = COMPARE;
            end
            COMPARE: begin
                // A request dropped during a burst lands here with req low.
                if (!req || hit)    state_d = IDLE;
                else if (valid && dirty) state_d = WRITEBACK;
                else                state_d = ALLOCATE;
            end
            WRITEBACK: begin
                if (pmem_resp) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                if (pmem_resp) state_d = COMPARE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        load_tag   = 1'b0;
        load_mem   = 1'b0;
        set_valid  = 1'b0;
        set_clean  = 1'b0;
        set_dirty  = 1'b0;
        load_lru   = 1'b0;
        way_sel    = 1'b0;
        addr_sel   = 1'b0;
        unique case (state_q)
            IDLE: ;
            COMPARE: begin
                if (req && hit) begin
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    if (mem_write) begin
                        load_mem  = 1'b1;
                        set_dirty = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                way_sel    = 1'b1;
                addr_sel   = 1'b1;
                pmem_write = 1'b1;
            end
            ALLOCATE: begin
                way_sel   = 1'b1;
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    load_mem  = 1'b1;
                    load_tag  = 1'b1;
                    set_valid = 1'b1;
                    set_clean = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef CACHE_PERF_CNT_EN
    logic             fill_q, fill_d;
    logic             hit_ev, miss_ev, wb_ev;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic [CNT_W-1:0] wb_q, wb_d;

    // A hit right after a fill is the tail of a miss, not a real hit.
    assign hit_ev  = (state_q == COMPARE) && req && hit && !fill_q;
    assign miss_ev = (state_q == COMPARE) && req && !hit;
    assign wb_ev   = (state_q == WRITEBACK) && pmem_resp;

    always_comb begin
        fill_d = fill_q;
        if (state_q == ALLOCATE && pmem_resp) fill_d = 1'b1;
        else if (state_q == COMPARE)          fill_d = 1'b0;
        hit_d  = hit_q;
        miss_d = miss_q;
        wb_d   = wb_q;
        if (hit_ev && !(&hit_q))   hit_d  = hit_q + 1'b1;
        if (miss_ev && !(&miss_q)) miss_d = miss_q + 1'b1;
        if (wb_ev && !(&wb_q))     wb_d   = wb_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q <= 1'b0;
            hit_q  <= '0;
            miss_q <= '0;
            wb_q   <= '0;
        end else begin
            fill_q <= fill_d;
            hit_q  <= hit_d;
            miss_q <= miss_d;
            wb_q   <= wb_d;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign wb_count   = wb_q;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Randomized bench for cache_control against a per-transaction
// timeline model of hit, clean-miss and dirty-miss sequences.
module tb_cache_control;

    logic clk = 1'b0;
    logic rst;
    logic mem_read, mem_write, mem_resp;
    logic hit, valid, dirty, pmem_resp;
    logic pmem_read, pmem_write, load_tag, load_mem;
    logic set_valid, set_clean, set_dirty, load_lru;
    logic way_sel, addr_sel;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_count, miss_count, wb_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int m_hits = 0;
    int m_miss = 0;
    int m_wb = 0;

    cache_control dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .hit(hit),
        .valid(valid), .dirty(dirty),
        .pmem_resp(pmem_resp), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .load_tag(load_tag),
        .load_mem(load_mem), .set_valid(set_valid),
        .set_clean(set_clean), .set_dirty(set_dirty),
        .load_lru(load_lru), .way_sel(way_sel),
        .addr_sel(addr_sel)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count),
        .wb_count(wb_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {resp,pr,pw,ltag,lmem,sval,sclean,sdirty,lru,way,addr}
    function automatic logic [10:0] outs();
        return {mem_resp, pmem_read, pmem_write, load_tag, load_mem,
                set_valid, set_clean, set_dirty, load_lru, way_sel,
                addr_sel};
    endfunction

    function automatic logic [10:0] resp_vec(input bit wr);
        return {1'b1, 2'b00, 1'b0, wr, 2'b00, wr, 1'b1, 2'b00};
    endfunction

    localparam logic [10:0] WB_VEC   = 11'b001_0000_0011;
    localparam logic [10:0] AL_VEC   = 11'b010_0000_0010;
    localparam logic [10:0] FILL_VEC = 11'b010_1111_0010;

    // kind: 0 hit, 1 clean miss, 2 dirty miss; drop_k = first cycle
    // with the request withdrawn (large value = never dropped).
    task automatic run_txn(input int kind, input bit rd, input bit wr,
                           input int lw, input int lr, input int drop_k);
        bit miss, wbk, req_on, noise;
        int a_s, t_end;
        logic [10:0] e;
        miss  = (kind != 0);
        wbk   = (kind == 2);
        a_s   = 2 + (wbk ? lw : 0);
        t_end = miss ? a_s + lr : 1;
        for (int k = 0; k <= t_end + 1; k++) begin
            @(negedge clk);
            req_on    = (k <= t_end) && (k < drop_k);
            mem_read  = req_on && rd;
            mem_write = req_on && wr;
            hit       = (kind == 0) || (miss && k == t_end);
            if (k == 1 && kind == 2) begin
                valid = 1'b1;
                dirty = 1'b1;
            end else if (k == 1 && kind == 1) begin
                valid = $urandom_range(0, 1);
                dirty = valid ? 1'b0 : 1'($urandom_range(0, 1));
            end else begin
                valid = $urandom_range(0, 1);
                dirty = $urandom_range(0, 1);
            end
            noise     = (k <= 1 || k >= t_end) && ($urandom_range(0, 1) == 1);
            pmem_resp = (wbk && k == 1 + lw) ||
                        (miss && k == a_s + lr - 1) || noise;
            #1;
            e = '0;
            if (!miss && k == 1)
                e = resp_vec(wr);
            else if (wbk && k >= 2 && k < a_s)
                e = WB_VEC;
            else if (miss && k >= a_s && k < t_end)
                e = (k == t_end - 1) ? FILL_VEC : AL_VEC;
            else if (miss && k == t_end && req_on)
                e = resp_vec(wr);
            chk($sformatf("kind%0d_k%0d", kind, k), 32'(outs()), 32'(e));
        end
        if (!miss) m_hits++;
        else m_miss++;
        if (wbk) m_wb++;
    endtask

    initial begin
        int kind, lw, lr, drop;
        bit rd, wr;
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0;
        hit = 1'b0; valid = 1'b0; dirty = 1'b0; pmem_resp = 1'b0;
        #1;
        chk("reset_outs", 32'(outs()), 32'd0);
        repeat (2) @(negedge clk);
        mem_read = 1'b1; hit = 1'b1; pmem_resp = 1'b1;
        #1;
        chk("reset_held_outs", 32'(outs()), 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_read = 1'b0; hit = 1'b0; pmem_resp = 1'b0;

        // Reset in the middle of a line fill
        @(negedge clk);
        mem_read = 1'b1; valid = 1'b1; dirty = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("alloc_pmem_read", 32'(pmem_read), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_pmem_read", 32'(pmem_read), 32'd0);
        chk("rst_outs", 32'(outs()), 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_read = 1'b0; pmem_resp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_idle", 32'(outs()), 32'd0);
        end
        pmem_resp = 1'b0;
`ifdef CACHE_PERF_CNT_EN
        chk("rst_miss_cnt", miss_count, 32'd0);
        chk("rst_hit_cnt", hit_count, 32'd0);
`endif

        run_txn(0, 1, 0, 1, 1, 1000);
        run_txn(0, 0, 1, 1, 1, 1000);
        run_txn(0, 1, 1, 1, 1, 1000);
        run_txn(1, 1, 0, 1, 5, 1000);
        run_txn(2, 1, 0, 3, 4, 1000);
        run_txn(2, 0, 1, 1, 1, 1000);

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            lw   = $urandom_range(1, 6);
            lr   = $urandom_range(1, 6);
            case ($urandom_range(0, 2))
                0: begin rd = 1; wr = 0; end
                1: begin rd = 0; wr = 1; end
                default: begin rd = 1; wr = 1; end
            endcase
            drop = 1000;
            if (kind == 2 && $urandom_range(0, 3) == 0)
                drop = 2 + $urandom_range(0, lw - 1);
            run_txn(kind, rd, wr, lw, lr, drop);
            if (drop != 1000) m_hits = m_hits;
        end

`ifdef CACHE_PERF_CNT_EN
        chk("hit_count", hit_count, 32'(m_hits));
        chk("miss_count", miss_count, 32'(m_miss));
        chk("wb_count", wb_count, 32'(m_wb));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
